execute_writeback: RTL and testbench

Execution and writeback stage on the issue side of the reservation station. It accepts up to three issued operations per cycle, one per functional-unit port FU1/FU2/FU3, and computes each in one cycle into a per-FU result buffer. A round-robin arbiter then drives one completion per cycle. An ALU result goes onto the wakeup bus that feeds the reservation station's `wakeup_tag`/`wakeup_val` and the ROB. A load/store result goes out as an address to the LSU. Per-FU ready signals back-pressure the reservation station.

---
 rtl/execute_writeback.sv | 208 ++++++++++++++++++++
 tb/tb_execute_writeback.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_writeback.sv
// Execute/writeback: three FU ports compute into per-FU result buffers; a round-robin arbiter retires one per cycle.
// Latency: one cycle from issue to broadcast at the earliest; outputs are combinational from the buffers, rr and ls_ready.
// Backpressure: FUn_ready drops while FU n holds an ungranted result; load/store results wait for ls_ready.
module execute_writeback #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6,
    parameter int ROB_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_FU1_valid,
    input  logic             issue_FU2_valid,
    input  logic             issue_FU3_valid,
    input  logic             issue_0_is_LS,
    input  logic             issue_0_alusrc,
    input  logic [TAG_W-1:0] issue_0_rd_tag,
    input  logic [ROB_W-1:0] issue_0_rob_num,
    input  logic [XLEN-1:0]  issue_0_rs1_val,
    input  logic [XLEN-1:0]  issue_0_rs2_val,
    input  logic [XLEN-1:0]  issue_0_imm,
    input  logic [3:0]       issue_0_alu_type,
    input  logic             issue_1_is_LS,
    input  logic             issue_1_alusrc,
    input  logic [TAG_W-1:0] issue_1_rd_tag,
    input  logic [ROB_W-1:0] issue_1_rob_num,
    input  logic [XLEN-1:0]  issue_1_rs1_val,
    input  logic [XLEN-1:0]  issue_1_rs2_val,
    input  logic [XLEN-1:0]  issue_1_imm,
    input  logic [3:0]       issue_1_alu_type,
    input  logic             issue_2_is_LS,
    input  logic             issue_2_alusrc,
    input  logic [TAG_W-1:0] issue_2_rd_tag,
    input  logic [ROB_W-1:0] issue_2_rob_num,
    input  logic [XLEN-1:0]  issue_2_rs1_val,
    input  logic [XLEN-1:0]  issue_2_rs2_val,
    input  logic [XLEN-1:0]  issue_2_imm,
    input  logic [3:0]       issue_2_alu_type,
    output logic             FU1_ready,
    output logic             FU2_ready,
    output logic             FU3_ready,
    input  logic             ls_ready,
    output logic             wakeup_valid,
    output logic [TAG_W-1:0] wakeup_tag,
    output logic [XLEN-1:0]  wakeup_val,
    output logic             complete_valid,
    output logic [ROB_W-1:0] complete_rob_num,
    output logic             ls_valid,
    output logic [XLEN-1:0]  ls_addr,
    output logic [XLEN-1:0]  ls_data,
    output logic [TAG_W-1:0] ls_rd_tag,
    output logic [ROB_W-1:0] ls_rob_num
);

    typedef struct packed {
        logic             is_ls;
        logic             alusrc;
        logic [TAG_W-1:0] tag;
        logic [ROB_W-1:0] rob;
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
        logic [XLEN-1:0]  imm;
        logic [3:0]       op;
    } issue_t;

    typedef struct packed {
        logic             is_ls;
        logic [TAG_W-1:0] tag;
        logic [ROB_W-1:0] rob;
        logic [XLEN-1:0]  val;
        logic [XLEN-1:0]  dat;
    } res_t;

    function automatic logic [XLEN-1:0] alu_op(input logic [3:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        r = '0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b1100: r = {{(XLEN-1){1'b0}}, (a < b)};
            4'b1000: r = a ^ b;
            4'b1001: r = a << b[4:0];
            4'b1010: r = a >> b[4:0];
            4'b1011: r = $signed(a) >>> b[4:0];
            default: r = '0;
        endcase
        return r;
    endfunction

    issue_t          iss [3];
    logic [2:0]      iss_vld;
    logic [2:0]      buf_vld_q, buf_vld_d;
    res_t            buf_q [3];
    res_t            buf_d [3];
    logic [1:0]      rr_q, rr_d;
    logic [2:0]      elig, gnt, rdy;
    logic [1:0]      ord [3];
    logic [1:0]      gnt_idx;
    logic            gnt_any;
    res_t            sel;
    logic [XLEN-1:0] opb;

    assign iss_vld = {issue_FU3_valid, issue_FU2_valid, issue_FU1_valid};
    assign iss[0]  = {issue_0_is_LS, issue_0_alusrc, issue_0_rd_tag, issue_0_rob_num,
                      issue_0_rs1_val, issue_0_rs2_val, issue_0_imm, issue_0_alu_type};
    assign iss[1]  = {issue_1_is_LS, issue_1_alusrc, issue_1_rd_tag, issue_1_rob_num,
                      issue_1_rs1_val, issue_1_rs2_val, issue_1_imm, issue_1_alu_type};
    assign iss[2]  = {issue_2_is_LS, issue_2_alusrc, issue_2_rd_tag, issue_2_rob_num,
                      issue_2_rs1_val, issue_2_rs2_val, issue_2_imm, issue_2_alu_type};

    // Search order starts one past the last winner and wraps.
    always_comb begin
        case (rr_q)
            2'd0:    ord = '{2'd1, 2'd2, 2'd0};
            2'd1:    ord = '{2'd2, 2'd0, 2'd1};
            default: ord = '{2'd0, 2'd1, 2'd2};
        endcase
        for (int i = 0; i < 3; i++) begin
            elig[i] = buf_vld_q[i] & (~buf_q[i].is_ls | ls_ready);
        end
        gnt_any = 1'b0;
        gnt_idx = rr_q;
        for (int k = 0; k < 3; k++) begin
            if (!gnt_any && elig[ord[k]]) begin
                gnt_any = 1'b1;
                gnt_idx = ord[k];
            end
        end
        gnt  = gnt_any ? (3'b001 << gnt_idx) : 3'b000;
        rdy  = ~buf_vld_q | gnt;
        rr_d = gnt_any ? gnt_idx : rr_q;
        sel  = buf_q[gnt_idx];
    end

    assign FU1_ready = rdy[0];
    assign FU2_ready = rdy[1];
    assign FU3_ready = rdy[2];

    // An accepted issue overwrites the buffer even when it is being retired this cycle.
    always_comb begin
        buf_vld_d = buf_vld_q;
        opb       = '0;
        for (int i = 0; i < 3; i++) begin
            buf_d[i] = buf_q[i];
            if (iss_vld[i] && rdy[i]) begin
                buf_vld_d[i]   = 1'b1;
                buf_d[i].is_ls = iss[i].is_ls;
                buf_d[i].tag   = iss[i].tag;
                buf_d[i].rob   = iss[i].rob;
                if (iss[i].is_ls) begin
                    buf_d[i].val = iss[i].rs1 + iss[i].imm;
                    buf_d[i].dat = iss[i].rs2;
                end else begin
                    opb          = iss[i].alusrc ? iss[i].imm : iss[i].rs2;
                    buf_d[i].val = alu_op(iss[i].op, iss[i].rs1, opb);
                    buf_d[i].dat = '0;
                end
            end else if (gnt[i]) begin
                buf_vld_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_vld_q <= '0;
            rr_q      <= 2'd2;
            for (int i = 0; i < 3; i++) buf_q[i] <= '0;
        end else begin
            buf_vld_q <= buf_vld_d;
            rr_q      <= rr_d;
            for (int i = 0; i < 3; i++) buf_q[i] <= buf_d[i];
        end
    end

    always_comb begin
        wakeup_valid     = 1'b0;
        wakeup_tag       = '0;
        wakeup_val       = '0;
        complete_valid   = 1'b0;
        complete_rob_num = '0;
        ls_valid         = 1'b0;
        ls_addr          = '0;
        ls_data          = '0;
        ls_rd_tag        = '0;
        ls_rob_num       = '0;
        if (gnt_any) begin
            if (sel.is_ls) begin
                ls_valid   = 1'b1;
                ls_addr    = sel.val;
                ls_data    = sel.dat;
                ls_rd_tag  = sel.tag;
                ls_rob_num = sel.rob;
            end else begin
                wakeup_valid     = 1'b1;
                wakeup_tag       = sel.tag;
                wakeup_val       = sel.val;
                complete_valid   = 1'b1;
                complete_rob_num = sel.rob;
            end
        end
    end

endmodule

// File: tb/tb_execute_writeback.sv
// Self-checking bench for execute_writeback: directed scenarios plus a randomized run against a behavioural model.
module tb_execute_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        iv [3];
    logic        il [3];
    logic        ia [3];
    logic [5:0]  it [3];
    logic [5:0]  ir [3];
    logic [31:0] i1 [3];
    logic [31:0] i2 [3];
    logic [31:0] im [3];
    logic [3:0]  io [3];
    logic        ls_ready;
    logic        FU1_ready, FU2_ready, FU3_ready;
    logic        wakeup_valid, complete_valid, ls_valid;
    logic [5:0]  wakeup_tag, complete_rob_num, ls_rd_tag, ls_rob_num;
    logic [31:0] wakeup_val, ls_addr, ls_data;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    bit          mv   [3];
    bit          mls  [3];
    logic [5:0]  mtag [3];
    logic [5:0]  mrob [3];
    logic [31:0] mval [3];
    logic [31:0] mdat [3];
    int          mrr;

    always #5 clk = ~clk;

    execute_writeback dut (
        .clk(clk), .reset(reset),
        .issue_FU1_valid(iv[0]), .issue_FU2_valid(iv[1]), .issue_FU3_valid(iv[2]),
        .issue_0_is_LS(il[0]), .issue_0_alusrc(ia[0]), .issue_0_rd_tag(it[0]), .issue_0_rob_num(ir[0]),
        .issue_0_rs1_val(i1[0]), .issue_0_rs2_val(i2[0]), .issue_0_imm(im[0]), .issue_0_alu_type(io[0]),
        .issue_1_is_LS(il[1]), .issue_1_alusrc(ia[1]), .issue_1_rd_tag(it[1]), .issue_1_rob_num(ir[1]),
        .issue_1_rs1_val(i1[1]), .issue_1_rs2_val(i2[1]), .issue_1_imm(im[1]), .issue_1_alu_type(io[1]),
        .issue_2_is_LS(il[2]), .issue_2_alusrc(ia[2]), .issue_2_rd_tag(it[2]), .issue_2_rob_num(ir[2]),
        .issue_2_rs1_val(i1[2]), .issue_2_rs2_val(i2[2]), .issue_2_imm(im[2]), .issue_2_alu_type(io[2]),
        .FU1_ready(FU1_ready), .FU2_ready(FU2_ready), .FU3_ready(FU3_ready),
        .ls_ready(ls_ready),
        .wakeup_valid(wakeup_valid), .wakeup_tag(wakeup_tag), .wakeup_val(wakeup_val),
        .complete_valid(complete_valid), .complete_rob_num(complete_rob_num),
        .ls_valid(ls_valid), .ls_addr(ls_addr), .ls_data(ls_data),
        .ls_rd_tag(ls_rd_tag), .ls_rob_num(ls_rob_num)
    );

    // Inputs change just after the falling edge; one tick spans exactly one rising edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_issue();
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; il[k] = 1'b0; ia[k] = 1'b0; it[k] = '0; ir[k] = '0;
            i1[k] = '0;   i2[k] = '0;   im[k] = '0;   io[k] = '0;
        end
    endtask

    task automatic set_op(input int k, input logic ls, input logic src, input logic [5:0] tag,
                          input logic [5:0] rob, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [3:0] op);
        iv[k] = 1'b1; il[k] = ls; ia[k] = src; it[k] = tag; ir[k] = rob;
        i1[k] = a;    i2[k] = b;  im[k] = imm; io[k] = op;
    endtask

    task automatic do_reset();
        clear_issue();
        ls_ready = 1'b1;
        reset    = 1'b0;
        tick();
        reset    = 1'b1;
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int sh;
        sh = int'(b[4:0]);
        r  = 32'd0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: r = (a < b) ? 32'd1 : 32'd0;
            4'b1000: r = a ^ b;
            4'b1001: begin r = a; for (int s = 0; s < sh; s++) r = {r[30:0], 1'b0};  end
            4'b1010: begin r = a; for (int s = 0; s < sh; s++) r = {1'b0, r[31:1]};  end
            4'b1011: begin r = a; for (int s = 0; s < sh; s++) r = {r[31], r[31:1]}; end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic test_reset();
        clear_issue();
        ls_ready = 1'b1;
        reset    = 1'b0;
        #1;
        checks++;
        if ({wakeup_valid, complete_valid, ls_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_valids: got %b expected 000", {wakeup_valid, complete_valid, ls_valid});
        end
        checks++;
        if ({wakeup_tag, wakeup_val, complete_rob_num, ls_addr, ls_data, ls_rd_tag, ls_rob_num} !== '0) begin
            errors++; $display("FAIL reset_data: got nonzero data outputs %h",
                               {wakeup_tag, wakeup_val, complete_rob_num, ls_addr, ls_data, ls_rd_tag, ls_rob_num});
        end
        checks++;
        if ({FU1_ready, FU2_ready, FU3_ready} !== 3'b111) begin
            errors++; $display("FAIL reset_ready: got %b expected 111", {FU1_ready, FU2_ready, FU3_ready});
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_single_add();
        do_reset();
        set_op(0, 1'b0, 1'b0, 6'd10, 6'd15, 32'd1, 32'd2, 32'd0, 4'b0010);
        #1;
        checks++;
        if (FU1_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b expected 1", FU1_ready); end
        tick();
        clear_issue();
        #1;
        checks++;
        if ({wakeup_valid, wakeup_tag, wakeup_val, complete_valid, complete_rob_num, ls_valid} !==
            {1'b1, 6'd10, 32'd3, 1'b1, 6'd15, 1'b0}) begin
            errors++; $display("FAIL add_broadcast: got v=%b tag=%0d val=%0h cv=%b rob=%0d lsv=%b expected 1/10/3/1/15/0",
                               wakeup_valid, wakeup_tag, wakeup_val, complete_valid, complete_rob_num, ls_valid);
        end
        tick();
        #1;
        checks++;
        if ({wakeup_valid, complete_valid, ls_valid} !== 3'b000) begin
            errors++; $display("FAIL add_after: got valids %b expected 000", {wakeup_valid, complete_valid, ls_valid});
        end
    endtask

    task automatic test_three_issue();
        logic [2:0] exp_rdy;
        do_reset();
        for (int k = 0; k < 3; k++)
            set_op(k, 1'b0, 1'b0, 6'(k + 1), 6'(k + 5), 32'(k + 1), 32'd10, 32'd0, 4'b0010);
        tick();
        clear_issue();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({wakeup_valid, wakeup_tag, wakeup_val, complete_rob_num} !== {1'b1, 6'(c + 1), 32'(c + 11), 6'(c + 5)}) begin
                errors++; $display("FAIL rr_order_%0d: got v=%b tag=%0d val=%0h rob=%0d expected tag %0d val %0h rob %0d",
                                   c, wakeup_valid, wakeup_tag, wakeup_val, complete_rob_num, c + 1, c + 11, c + 5);
            end
            exp_rdy = (c == 0) ? 3'b100 : (c == 1) ? 3'b110 : 3'b111;
            checks++;
            if ({FU1_ready, FU2_ready, FU3_ready} !== exp_rdy) begin
                errors++; $display("FAIL rr_ready_%0d: got %b expected %b", c, {FU1_ready, FU2_ready, FU3_ready}, exp_rdy);
            end
            tick();
        end
        #1;
        checks++;
        if (wakeup_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b expected 0", wakeup_valid); end
    endtask

    task automatic test_opcodes();
        logic [3:0]  ops [13];
        logic [31:0] av  [13];
        logic [31:0] bv  [13];
        logic [31:0] ev  [13];
        logic        src;
        ops = '{4'b0110, 4'b1011, 4'b1010, 4'b0111, 4'b1100, 4'b1111, 4'b0000,
                4'b0001, 4'b1000, 4'b1001, 4'b0010, 4'b0111, 4'b0011};
        av  = '{32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hF0F0F0F0,
                32'hF0F0F0F0, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'h00000005};
        bv  = '{32'd4, 32'd4, 32'd4, 32'd1, 32'd1, 32'd4, 32'hFF00FF00,
                32'h0F000000, 32'd4, 32'h00000025, 32'd2, 32'hFFFFFFFF, 32'd5};
        ev  = '{32'h7FFFFFFC, 32'hF8000000, 32'h08000000, 32'd1, 32'd0, 32'd0, 32'hF000F000,
                32'hFFF0F0F0, 32'h80000004, 32'h00000020, 32'h00000001, 32'd0, 32'd0};
        do_reset();
        for (int i = 0; i < 13; i++) begin
            src = i[0];
            // the unselected operand is the complement, so a wrong mux choice shows up
            set_op(0, 1'b0, src, 6'(i), 6'(i), av[i], src ? ~bv[i] : bv[i], src ? bv[i] : ~bv[i], ops[i]);
            tick();
            clear_issue();
            #1;
            checks++;
            if ({wakeup_valid, wakeup_val} !== {1'b1, ev[i]}) begin
                errors++; $display("FAIL opcode_%b_%0d: got v=%b val=%h expected v=1 val=%h",
                                   ops[i], i, wakeup_valid, wakeup_val, ev[i]);
            end
        end
        tick();
    endtask

    task automatic test_load_store();
        do_reset();
        ls_ready = 1'b0;
        set_op(2, 1'b1, 1'b1, 6'd7, 6'd9, 32'h100, 32'hAB, 32'h20, 4'b1111);
        set_op(0, 1'b0, 1'b0, 6'd4, 6'd3, 32'd5, 32'd6, 32'd0, 4'b0010);
        tick();
        clear_issue();
        #1;
        checks++;
        if ({wakeup_valid, wakeup_tag, wakeup_val, ls_valid, FU3_ready} !== {1'b1, 6'd4, 32'd11, 1'b0, 1'b0}) begin
            errors++; $display("FAIL ls_alu_first: got wv=%b tag=%0d val=%0h lsv=%b fu3rdy=%b expected 1/4/b/0/0",
                               wakeup_valid, wakeup_tag, wakeup_val, ls_valid, FU3_ready);
        end
        tick();
        #1;
        checks++;
        if ({wakeup_valid, ls_valid, FU3_ready} !== 3'b000) begin
            errors++; $display("FAIL ls_blocked: got wv/lsv/fu3rdy=%b expected 000", {wakeup_valid, ls_valid, FU3_ready});
        end
        ls_ready = 1'b1;
        #1;
        checks++;
        if ({ls_valid, ls_addr, ls_data, ls_rd_tag, ls_rob_num} !== {1'b1, 32'h120, 32'hAB, 6'd7, 6'd9}) begin
            errors++; $display("FAIL ls_issue: got v=%b addr=%h data=%h tag=%0d rob=%0d expected 1/120/ab/7/9",
                               ls_valid, ls_addr, ls_data, ls_rd_tag, ls_rob_num);
        end
        checks++;
        if ({wakeup_valid, complete_valid, FU3_ready} !== 3'b001) begin
            errors++; $display("FAIL ls_no_wakeup: got wv/cv/fu3rdy=%b expected 001", {wakeup_valid, complete_valid, FU3_ready});
        end
        tick();
        #1;
        checks++;
        if (ls_valid !== 1'b0) begin errors++; $display("FAIL ls_drain: got %b expected 0", ls_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) set_op(0, 1'b0, 1'b1, 6'(20 + i), 6'(i), 32'(i), 32'd0, 32'd100, 4'b0010);
            else       clear_issue();
            #1;
            checks++;
            if (FU1_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, FU1_ready); end
            if (i > 0) begin
                checks++;
                if ({wakeup_valid, wakeup_tag, wakeup_val} !== {1'b1, 6'(19 + i), 32'(99 + i)}) begin
                    errors++; $display("FAIL b2b_wakeup_%0d: got v=%b tag=%0d val=%0d expected 1/%0d/%0d",
                                       i, wakeup_valid, wakeup_tag, wakeup_val, 19 + i, 99 + i);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        ls_ready = 1'b0;
        set_op(0, 1'b0, 1'b0, 6'd33, 6'd1, 32'd1, 32'd1, 32'd0, 4'b0010);
        set_op(1, 1'b0, 1'b0, 6'd34, 6'd2, 32'd2, 32'd2, 32'd0, 4'b0010);
        set_op(2, 1'b1, 1'b0, 6'd35, 6'd3, 32'd3, 32'd3, 32'd3, 4'b0000);
        tick();
        clear_issue();
        #1;
        checks++;
        if ({wakeup_valid, FU2_ready, FU3_ready} !== 3'b100) begin
            errors++; $display("FAIL mid_full: got wv/fu2rdy/fu3rdy=%b expected 100", {wakeup_valid, FU2_ready, FU3_ready});
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({wakeup_valid, complete_valid, ls_valid, FU1_ready, FU2_ready, FU3_ready} !== 6'b000111) begin
            errors++; $display("FAIL mid_reset: got %b expected 000111",
                               {wakeup_valid, complete_valid, ls_valid, FU1_ready, FU2_ready, FU3_ready});
        end
        tick();
        reset    = 1'b1;
        ls_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({wakeup_valid, complete_valid, ls_valid, wakeup_tag, ls_rd_tag} !== 15'd0) begin
                errors++; $display("FAIL mid_stale_%0d: got wv=%b cv=%b lsv=%b tag=%0d lstag=%0d expected all 0",
                                   c, wakeup_valid, complete_valid, ls_valid, wakeup_tag, ls_rd_tag);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int          gi;
        int          idx;
        bit          mrdy [3];
        logic [2:0]  exp_rdy;
        logic [45:0] exp_w;
        logic [76:0] exp_l;
        do_reset();
        for (int i = 0; i < 3; i++) mv[i] = 1'b0;
        mrr = 2;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                iv[k] = ($urandom_range(0, 3) != 0);
                il[k] = ($urandom_range(0, 3) == 0);
                ia[k] = $urandom_range(0, 1) == 1;
                it[k] = 6'($urandom);
                ir[k] = 6'($urandom);
                i1[k] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
                i2[k] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
                im[k] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
                io[k] = 4'($urandom_range(0, 15));
            end
            ls_ready = ($urandom_range(0, 3) != 0);
            #1;
            gi = -1;
            for (int k = 1; k <= 3; k++) begin
                idx = (mrr + k) % 3;
                if (gi < 0 && mv[idx] && (!mls[idx] || ls_ready)) gi = idx;
            end
            for (int i = 0; i < 3; i++) begin
                mrdy[i]       = !mv[i] || (gi == i);
                exp_rdy[2 - i] = mrdy[i];
            end
            exp_w = '0;
            exp_l = '0;
            if (gi >= 0 && !mls[gi]) exp_w = {1'b1, mtag[gi], mval[gi], 1'b1, mrob[gi]};
            if (gi >= 0 &&  mls[gi]) exp_l = {1'b1, mval[gi], mdat[gi], mtag[gi], mrob[gi]};
            checks++;
            if ({FU1_ready, FU2_ready, FU3_ready} !== exp_rdy) begin
                errors++; $display("FAIL rand_ready_%0d: got %b expected %b", cyc, {FU1_ready, FU2_ready, FU3_ready}, exp_rdy);
            end
            checks++;
            if ({wakeup_valid, wakeup_tag, wakeup_val, complete_valid, complete_rob_num} !== exp_w) begin
                errors++; $display("FAIL rand_wakeup_%0d: got %h expected %h", cyc,
                                   {wakeup_valid, wakeup_tag, wakeup_val, complete_valid, complete_rob_num}, exp_w);
            end
            checks++;
            if ({ls_valid, ls_addr, ls_data, ls_rd_tag, ls_rob_num} !== exp_l) begin
                errors++; $display("FAIL rand_ls_%0d: got %h expected %h", cyc,
                                   {ls_valid, ls_addr, ls_data, ls_rd_tag, ls_rob_num}, exp_l);
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                if (iv[i] && mrdy[i]) begin
                    mv[i]   = 1'b1;
                    mls[i]  = il[i];
                    mtag[i] = it[i];
                    mrob[i] = ir[i];
                    if (il[i]) begin
                        mval[i] = i1[i] + im[i];
                        mdat[i] = i2[i];
                    end else begin
                        mval[i] = ref_alu(io[i], i1[i], ia[i] ? im[i] : i2[i]);
                        mdat[i] = 32'd0;
                    end
                end else if (gi == i) begin
                    mv[i] = 1'b0;
                end
            end
            if (gi >= 0) mrr = gi;
        end
        clear_issue();
    endtask

    initial begin
        reset = 1'b0;
        clear_issue();
        ls_ready = 1'b1;
        test_reset();
        test_single_add();
        test_three_issue();
        test_opcodes();
        test_load_store();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
